ram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that owns the pointers, occupancy tracking and valid/ready handshakes around a single `RAM_1R_1W`-style storage array. It sits directly upstream of the RAM, driving its write and read ports, and consumes its combinational read data into a registered show-ahead output stage. Producers and consumers in the pipeline see a plain valid/ready stream; the RAM is instantiated alongside by the parent.

---
 rtl/ram_fifo_ctrl.sv | 95 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller around an external 1R1W RAM with a show-ahead output register
// Optional same-cycle empty bypass: define FIFO_CTRL_BYPASS_EN.
module ram_fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int SIZE = 16,
  localparam int ADDR_WIDTH = $clog2(SIZE),
  localparam int LEVEL_WIDTH = ADDR_WIDTH + 1
) (
  input  logic                   aClock,
  input  logic                   aResetN,
  input  logic                   aFlush,
  input  logic                   aWriteValid,
  input  logic [DEPTH-1:0]       aWriteData,
  output logic                   anOutWriteReady,
  output logic                   anOutReadValid,
  output logic [DEPTH-1:0]       anOutReadData,
  input  logic                   aReadReady,
  output logic [LEVEL_WIDTH-1:0] anOutLevel,
  output logic [ADDR_WIDTH-1:0]  anOutRamWriteAddress,
  output logic [DEPTH-1:0]       anOutRamWriteData,
  output logic                   anOutRamWriteEnable,
  output logic [ADDR_WIDTH-1:0]  anOutRamReadAddress,
  output logic                   anOutRamReadEnable,
  input  logic [DEPTH-1:0]       aRamReadData
);

  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr;
  logic [LEVEL_WIDTH-1:0] ram_count;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   out_valid;
  logic [DEPTH-1:0]       out_data;

  logic active;
  logic push;
  logic pop;
  logic bypass;
  logic load;

  always_comb begin
    active          = aResetN && !aFlush;
    anOutWriteReady = active && (ram_count < LEVEL_WIDTH'(SIZE));
    push            = aWriteValid && anOutWriteReady;
    pop             = out_valid && aReadReady;
`ifdef FIFO_CTRL_BYPASS_EN
    // Empty RAM: pointers are equal, so the RAM's write-through bridge hands back aWriteData.
    bypass          = (ram_count == '0) && push;
`else
    bypass          = 1'b0;
`endif
    load            = active && (!out_valid || pop) && ((ram_count != '0) || bypass);
  end

  assign anOutReadValid       = out_valid;
  assign anOutReadData        = out_data;
  assign anOutLevel           = level;
  assign anOutRamWriteAddress = wr_ptr;
  assign anOutRamWriteData    = aWriteData;
  assign anOutRamWriteEnable  = push;
  assign anOutRamReadAddress  = rd_ptr;
  assign anOutRamReadEnable   = load;

  always_ff @(posedge aClock) begin
    if (!aResetN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (aFlush) begin
      // RAM contents and the stale output word are left in place; only tracking is cleared.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (load) begin
        rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
        out_data  <= aRamReadData;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      // A bypass load counts as a push and a RAM read, leaving ram_count unchanged.
      ram_count <= ram_count + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(load);
      level     <= level + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(pop);
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - randomized and directed bench for ram_fifo_ctrl against a queue model
// Honors FIFO_CTRL_BYPASS_EN for expected write-to-read latency.
module tb_ram_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int SIZE = 16;
  localparam int AW = 4;
  localparam int LW = 5;
`ifdef FIFO_CTRL_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic             flush;
  logic             wvalid;
  logic [DEPTH-1:0] wdata;
  logic             wready;
  logic             rvalid;
  logic [DEPTH-1:0] rdata;
  logic             rready;
  logic [LW-1:0]    level;
  logic [AW-1:0]    ram_wa;
  logic [DEPTH-1:0] ram_wd;
  logic             ram_we;
  logic [AW-1:0]    ram_ra;
  logic             ram_re;
  logic [DEPTH-1:0] ram_rd;

  ram_fifo_ctrl #(.DEPTH(DEPTH), .SIZE(SIZE)) dut (
    .aClock(clk),
    .aResetN(resetn),
    .aFlush(flush),
    .aWriteValid(wvalid),
    .aWriteData(wdata),
    .anOutWriteReady(wready),
    .anOutReadValid(rvalid),
    .anOutReadData(rdata),
    .aReadReady(rready),
    .anOutLevel(level),
    .anOutRamWriteAddress(ram_wa),
    .anOutRamWriteData(ram_wd),
    .anOutRamWriteEnable(ram_we),
    .anOutRamReadAddress(ram_ra),
    .anOutRamReadEnable(ram_re),
    .aRamReadData(ram_rd)
  );

  // Storage array with combinational read and same-address write bridging.
  logic [DEPTH-1:0] mem [SIZE];
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
  end
  assign ram_rd = (ram_we && ram_wa == ram_ra) ? ram_wd : mem[ram_ra];

  typedef struct {
    logic [DEPTH-1:0] d;
    int               t;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input logic wv, input logic [DEPTH-1:0] wd, input logic rr,
                      input logic fl, input logic rn);
    logic ev;
    logic er;
    @(negedge clk);
    wvalid = wv;
    wdata  = wd;
    rready = rr;
    flush  = fl;
    resetn = rn;
    #1;
    ev = (q.size() > 0) && (cyc >= q[0].t + LAT);
    er = rn && !fl && ((int'(q.size()) - int'(ev)) < SIZE);
    check("write_ready", 32'(wready), 32'(er));
    check("read_valid", 32'(rvalid), 32'(ev));
    check("level", 32'(level), 32'(q.size()));
    check("ram_write_enable", 32'(ram_we), 32'(er && wv));
    if (ev) check("read_data", 32'(rdata), 32'(q[0].d));
    acc = er && wv;
    if (!rn || fl) begin
      q.delete();
    end else begin
      if (ev && rr) void'(q.pop_front());
      if (er && wv) q.push_back('{wd, cyc});
    end
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    int idx;
    resetn = 1'b0;
    flush  = 1'b0;
    wvalid = 1'b1;
    wdata  = 8'h11;
    rready = 1'b0;
    @(posedge clk);

    // Reset held with a producer asserting valid.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    check("reset_read_data", 32'(rdata), 32'h0);
    check("reset_level", 32'(level), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Single word, consumer stalled, then popped.
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("single_held", 32'(rdata), 32'hA5);
    drain(3);

    // Fill past capacity, then a single pop.
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("full_level", 32'(level), 32'd17);
    check("full_ready", 32'(wready), 32'h0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("after_pop_ready", 32'(wready), 32'h1);
    check("after_pop_data", 32'(rdata), 32'h1);
    drain(20);

    // Continuous push of 0..39 with a toggling consumer.
    idx = 0;
    for (int i = 0; i < 200 && idx < 40; i++) begin
      step(1'b1, 8'(idx), 1'(i % 2), 1'b0, 1'b1);
      if (acc) idx++;
    end
    check("wrap_all_accepted", 32'(idx), 32'd40);
    drain(40);

    // Steady push and pop at level 5.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("steady_level", 32'(level), 32'd5);

    // Flush with a concurrent write, then a fresh word.
    step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("flush_level", 32'(level), 32'h0);
    check("flush_valid", 32'(rvalid), 32'h0);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("flush_first_word", 32'(rdata), 32'h3C);
    drain(3);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 300) != 0));
    end
    drain(25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
